wb_link_select_stage: RTL and testbench

- Registered write-back select stage for the MIPS datapath; generalises the JAL/JALR write-back multiplexer.
- Chooses between the link address (zero-extended PC, optional offset) and the MemToReg result, and resolves the destination register for JAL.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes and a synchronous flush, so write-back can stall without dropping instructions.

---
 rtl/wb_link_select_stage.sv | 104 ++++++++++
 tb/tb_wb_link_select_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_link_select_stage.sv
// Write-back select stage: picks link address or MemToReg result, resolves the
// JAL destination, and buffers results in a 2-entry skid FIFO with flush.
module wb_link_select_stage #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 11,
  parameter int REG_AW      = 5,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   next_pc,
  input  logic [DATA_W-1:0] mem_to_reg_data,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              reg_write,
  input  logic              jal,
  input  logic              jalr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_reg,
  output logic              wb_write
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fillState_e;

  fillState_e fillState, fillStateNext;

  logic [DATA_W-1:0] dataMem [2];
  logic [REG_AW-1:0] regMem  [2];
  logic              weMem   [2];
  logic              rdPtr, wrPtr;

  logic              pushEn, popEn;
  logic [PC_W-1:0]   linkAddr;
  logic [DATA_W-1:0] selData;
  logic [REG_AW-1:0] selReg;
  logic              selWe;

  assign in_ready  = reset && (fillState != FULL);
  assign out_valid = (fillState != EMPTY);
  assign pushEn    = in_valid && in_ready;
  assign popEn     = out_valid && out_ready;

  // Link address wraps in the PC width before zero-extension.
  assign linkAddr = next_pc + PC_W'(LINK_OFFSET);
  assign selData  = (jal || jalr) ? DATA_W'(linkAddr) : mem_to_reg_data;
  assign selReg   = jal ? REG_AW'(LINK_REG) : dest_reg;
  assign selWe    = (jal || jalr || reg_write) && (selReg != '0);

  always_comb begin
    fillStateNext = fillState;
    if (flush) begin
      fillStateNext = EMPTY;
    end else begin
      unique case ({pushEn, popEn})
        2'b10:   fillStateNext = (fillState == EMPTY) ? ONE : FULL;
        2'b01:   fillStateNext = (fillState == FULL) ? ONE : EMPTY;
        default: fillStateNext = fillState;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fillState <= EMPTY;
      rdPtr     <= 1'b0;
      wrPtr     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        dataMem[i] <= '0;
        regMem[i]  <= '0;
        weMem[i]   <= 1'b0;
      end
    end else begin
      fillState <= fillStateNext;
      if (flush) begin
        rdPtr <= 1'b0;
        wrPtr <= 1'b0;
      end else begin
        if (pushEn) begin
          dataMem[wrPtr] <= selData;
          regMem[wrPtr]  <= selReg;
          weMem[wrPtr]   <= selWe;
          wrPtr          <= ~wrPtr;
        end
        if (popEn) begin
          rdPtr <= ~rdPtr;
        end
      end
    end
  end

  assign wb_data  = out_valid ? dataMem[rdPtr] : '0;
  assign wb_reg   = out_valid ? regMem[rdPtr]  : '0;
  assign wb_write = out_valid && weMem[rdPtr];

endmodule

// File: tb/tb_wb_link_select_stage.sv
// Scoreboard bench: two stages (link offset 0 and 1) share stimulus; a queue
// model of the FIFO predicts every output, compared on the falling edge.
module tb_wb_link_select_stage;

  logic        clock = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic [10:0] nextPc = '0;
  logic [31:0] memData = '0;
  logic [4:0]  destReg = '0;
  logic        regWrite = 1'b0;
  logic        jalIn = 1'b0;
  logic        jalrIn = 1'b0;
  logic        flushIn = 1'b0;
  logic        outReady = 1'b0;

  logic        inReady0, outValid0, wbWrite0;
  logic        inReady1, outValid1, wbWrite1;
  logic [31:0] wbData0, wbData1;
  logic [4:0]  wbReg0, wbReg1;

  always #5 clock = ~clock;

  wb_link_select_stage #(.DATA_W(32), .PC_W(11), .REG_AW(5), .LINK_REG(31), .LINK_OFFSET(0)) dut0 (
    .clock(clock), .reset(rstN), .in_valid(inValid), .in_ready(inReady0),
    .next_pc(nextPc), .mem_to_reg_data(memData), .dest_reg(destReg),
    .reg_write(regWrite), .jal(jalIn), .jalr(jalrIn), .flush(flushIn),
    .out_valid(outValid0), .out_ready(outReady), .wb_data(wbData0),
    .wb_reg(wbReg0), .wb_write(wbWrite0)
  );

  wb_link_select_stage #(.DATA_W(32), .PC_W(11), .REG_AW(5), .LINK_REG(31), .LINK_OFFSET(1)) dut1 (
    .clock(clock), .reset(rstN), .in_valid(inValid), .in_ready(inReady1),
    .next_pc(nextPc), .mem_to_reg_data(memData), .dest_reg(destReg),
    .reg_write(regWrite), .jal(jalIn), .jalr(jalrIn), .flush(flushIn),
    .out_valid(outValid1), .out_ready(outReady), .wb_data(wbData1),
    .wb_reg(wbReg1), .wb_write(wbWrite1)
  );

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  r;
    logic        we;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   monActive = 1'b0;
  bit   pRst = 1'b0;
  bit   pFlush = 1'b0;
  bit   pAcc = 1'b0;
  exp_t pEnt;

  function automatic exp_t model(input logic [10:0] pc, input logic [31:0] md,
                                 input logic [4:0] dr, input bit rw, input bit j, input bit jr);
    exp_t e;
    int   link0, link1;
    link0 = int'(pc) % 2048;
    link1 = (int'(pc) + 1) % 2048;
    e.d0 = (j || jr) ? 32'(link0) : md;
    e.d1 = (j || jr) ? 32'(link1) : md;
    e.r  = j ? 5'd31 : dr;
    e.we = (j || jr || rw) && (e.r != 5'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the previous cycle's effect on the model is committed first.
  task automatic drive(input bit rst, input bit iv, input logic [10:0] pc, input logic [31:0] md,
                       input logic [4:0] dr, input bit rw, input bit j, input bit jr,
                       input bit fl, input bit ordy);
    @(posedge clock);
    if (!pRst || pFlush) expQ.delete();
    else if (pAcc) expQ.push_back(pEnt);
    monActive = 1'b1;
    #1;
    rstN = rst; inValid = iv; nextPc = pc; memData = md; destReg = dr;
    regWrite = rw; jalIn = j; jalrIn = jr; flushIn = fl; outReady = ordy;
    pRst   = rst;
    pFlush = fl;
    pAcc   = rst && iv && (expQ.size() < 2);
    pEnt   = model(pc, md, dr, rw, j, jr);
  endtask

  task automatic idle(input bit ordy);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  always @(negedge clock) begin
    if (monActive) begin
      chk("in_ready0", 32'(inReady0), 32'(rstN && (expQ.size() < 2)));
      chk("in_ready1", 32'(inReady1), 32'(rstN && (expQ.size() < 2)));
      chk("out_valid0", 32'(outValid0), 32'(expQ.size() != 0));
      chk("out_valid1", 32'(outValid1), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        chk("wb_data0", wbData0, expQ[0].d0);
        chk("wb_data1", wbData1, expQ[0].d1);
        chk("wb_reg0", 32'(wbReg0), 32'(expQ[0].r));
        chk("wb_reg1", 32'(wbReg1), 32'(expQ[0].r));
        chk("wb_write0", 32'(wbWrite0), 32'(expQ[0].we));
        chk("wb_write1", 32'(wbWrite1), 32'(expQ[0].we));
        if (outReady) void'(expQ.pop_front());
      end else begin
        chk("idle_data0", wbData0, 32'h0);
        chk("idle_data1", wbData1, 32'h0);
        chk("idle_reg0", 32'(wbReg0), 32'h0);
        chk("idle_write0", 32'(wbWrite0), 32'h0);
        chk("idle_write1", 32'(wbWrite1), 32'h0);
      end
    end
  end

  initial begin
    bit          fl, rs, j, jr;
    logic [4:0]  dr;

    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // JAL, JALR with wrap on the offset-1 stage, normal writes incl. $zero, JAL+JALR
    drive(1'b1, 1'b1, 11'h07F, 32'h12345678, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 11'h7FF, 32'h0BADF00D, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 11'h123, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 11'h123, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 11'h400, 32'hCAFEF00D, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 11'h010, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Backpressure: A, B fill the FIFO, C is refused
    drive(1'b1, 1'b1, '0, 32'hAAAA0001, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, '0, 32'hBBBB0002, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, '0, 32'hCCCC0003, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, '0, 32'hCCCC0003, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a same-cycle input
    drive(1'b1, 1'b1, '0, 32'h11110001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, '0, 32'h22220002, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, '0, 32'h33330003, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Reset with one entry held
    drive(1'b1, 1'b1, '0, 32'h44440004, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 19) == 0);
      j  = ($urandom_range(0, 5) == 0);
      jr = ($urandom_range(0, 5) == 0);
      dr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive(rs, ($urandom_range(0, 9) < 7), 11'($urandom), $urandom, dr,
            1'($urandom), j, jr, fl, ($urandom_range(0, 9) < 6));
    end

    repeat (4) idle(1'b1);
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
